axi_dw_distributor: RTL and testbench
=====================================

// Module: axi_dw_distributor
// PURPOSE
// - Target-side write-data steering for the AXI node: takes one master's W channel and routes each
//   burst to one of N_INIT_PORT init-side W channels, each feeding that init port's write-data arbiter.
// - The destination of every burst is pushed in AW order from the address decode stage.
// - Beats are steered in FIFO order, and the FIFO head is retired on the wlast handshake.
// PARAMETERS
// - AXI_DATA_W    64                   write data width
// - AXI_USER_W    6                    wuser width
// - N_INIT_PORT   4                    number of init-side (slave) W outputs, >=2
// - LOG_N_INIT    $clog2(N_INIT_PORT)  binary destination width
// - FIFO_DEPTH    8                    route FIFO entries, power of two, >=2
// - AXI_NUMBYTES  AXI_DATA_W/8         strobe width
// PORTS
// - clk              in   1                              clock; all logic on rising edge
// - rst              in   1                              synchronous, active-high reset
// - wdata_i          in   AXI_DATA_W                     master write data
// - wstrb_i          in   AXI_NUMBYTES                   master byte strobes
// - wlast_i          in   1                              last beat of burst
// - wuser_i          in   AXI_USER_W                     master user sideband
// - wvalid_i         in   1                              master beat valid
// - wready_o         out  1                              beat accepted by the selected init port
// - wdata_o          out  N_INIT_PORT x AXI_DATA_W       per-init data (broadcast)
// - wstrb_o          out  N_INIT_PORT x AXI_NUMBYTES     per-init strobes (broadcast)
// - wlast_o          out  N_INIT_PORT                    per-init last (broadcast)
// - wuser_o          out  N_INIT_PORT x AXI_USER_W       per-init user (broadcast)
// - wvalid_o         out  N_INIT_PORT                    per-init valid, at most one bit high
// - wready_i         in   N_INIT_PORT                    per-init ready
// - push_ID_i        in   1                              push a destination (AW handshake)
// - ID_i             in   LOG_N_INIT+N_INIT_PORT         destination as {BIN_ID, OH_ID}
// - grant_FIFO_ID_o  out  1                              route FIFO not full
// - burst_overrun_o  out  1                              sticky flag: burst exceeded 256 beats
// BEHAVIOUR
// - Reset (rst=1 at a clock edge): FIFO emptied, FSM->IDLE, beat counter=0, burst_overrun_o=0.
//   After reset: wvalid_o=0, wready_o=0, grant_FIFO_ID_o=1. Reset mid-burst discards all queued routes.
// - Datapath: wdata/wstrb/wlast/wuser are broadcast combinationally to every output. Zero latency, no register.
// - Head: valid_ID = FIFO not empty. Head is {BIN, OH}.
//   - wvalid_o = OH & {N{wvalid_i & valid_ID}}.
//   - wready_o = wready_i[BIN] & valid_ID.
//   - When the FIFO is empty, all valids and wready_o are 0 and the master stalls.
// - FSM states: IDLE, BURST.
//   - IDLE: on an accepted beat (wvalid_i & wready_o) with wlast_i=1, pop and stay in IDLE.
//     With wlast_i=0, go to BURST with no pop.
//   - BURST: the head is held. A last-beat handshake pops and returns to IDLE; any other cycle stays in BURST.
// - Route FIFO: not fall-through. A pushed entry is visible at the head the cycle after the push.
//   - grant_FIFO_ID_o = ~full. A push while full is dropped; a pop still occurs.
//   - Push and pop in the same cycle: both take effect; the count is unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
// - Beat counter: 8 bits.
//   - Increments on each accepted non-last beat; cleared on the accepted last beat.
//   - An accepted non-last beat while the counter = 255 sets burst_overrun_o. It stays set until reset.
//   - Routing is unaffected by an overrun.
// - OH must equal 1<<BIN; a simulation assertion fires on mismatch at the head.
// STRUCTURE
// - Package axi_dw_pkg: FSM enum dw_state_e {IDLE, BURST}; constant BEAT_CNT_W=8.
// - One sub-module, axi_dw_route_fifo: synchronous, active-high reset FIFO.
//   Ports: push, pop, data in, data out, full, empty.
// - Top level: FSM, beat counter, overrun flag, valid/ready steering.
// TESTING
// - Reset, then push ID for BIN=2; next cycle send a 1-beat burst with wready_i[2]=1
//   -> wvalid_o=4'b0100, wready_o=1, FIFO empty afterwards.
// - Push BIN=1 then BIN=3; send a 4-beat burst then a 2-beat burst
//   -> beats 1-4 appear only on port 1, beats 5-6 only on port 3, FSM back in IDLE.
// - Fill FIFO with 8 pushes -> grant_FIFO_ID_o=0. A 9th push is dropped.
//   After one last-beat pop, grant_FIFO_ID_o=1.
// - wready_i[BIN]=0 mid-burst for 3 cycles -> wready_o=0, head held, no pop. Burst resumes intact.
// - Send a 257-beat burst with wlast only on beat 257 -> burst_overrun_o=1 from the cycle after beat 256.
//   Then assert rst mid-burst -> flag=0, FIFO empty, wvalid_o=0.

Source files
------------

// File: rtl/axi_dw_pkg.sv
// Shared types and constants for the write-data distributor.
package axi_dw_pkg;

  // Width of the per-burst beat counter used for overrun detection
  localparam int BEAT_CNT_W = 8;

  // Burst tracking state: IDLE between bursts, BURST once a non-last beat was taken
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } dw_state_e;

endpackage

// File: rtl/axi_dw_route_fifo.sv
// Route FIFO holding burst destinations in AW order. Head is read
// combinationally from the storage array; a pushed entry becomes visible
// at the head one cycle after the push (no fall-through).
module axi_dw_route_fifo #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              push_en, pop_en;

  // A push into a full FIFO is dropped; a pop from an empty FIFO is ignored
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // Storage write; contents need no reset since occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of two)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_dw_distributor.sv
// Write-data steering: routes each W burst of one master to the init port
// named at the head of the route FIFO, retiring the head on the wlast beat.
module axi_dw_distributor
  import axi_dw_pkg::*;
#(
  parameter int AXI_DATA_W   = 64,
  parameter int AXI_USER_W   = 6,
  parameter int N_INIT_PORT  = 4,
  parameter int LOG_N_INIT   = $clog2(N_INIT_PORT),
  parameter int FIFO_DEPTH   = 8,
  parameter int AXI_NUMBYTES = AXI_DATA_W/8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [AXI_DATA_W-1:0]                     wdata_i,
  input  logic [AXI_NUMBYTES-1:0]                   wstrb_i,
  input  logic                                      wlast_i,
  input  logic [AXI_USER_W-1:0]                     wuser_i,
  input  logic                                      wvalid_i,
  output logic                                      wready_o,
  output logic [N_INIT_PORT-1:0][AXI_DATA_W-1:0]    wdata_o,
  output logic [N_INIT_PORT-1:0][AXI_NUMBYTES-1:0]  wstrb_o,
  output logic [N_INIT_PORT-1:0]                    wlast_o,
  output logic [N_INIT_PORT-1:0][AXI_USER_W-1:0]    wuser_o,
  output logic [N_INIT_PORT-1:0]                    wvalid_o,
  input  logic [N_INIT_PORT-1:0]                    wready_i,
  input  logic                                      push_ID_i,
  input  logic [LOG_N_INIT+N_INIT_PORT-1:0]         ID_i,
  output logic                                      grant_FIFO_ID_o,
  output logic                                      burst_overrun_o
);

  localparam int ID_W = LOG_N_INIT + N_INIT_PORT;

  logic [ID_W-1:0]        head_id;
  logic [LOG_N_INIT-1:0]  head_bin;
  logic [N_INIT_PORT-1:0] head_oh;
  logic                   fifo_full, fifo_empty, valid_id;
  logic                   beat_hs, last_hs;

  dw_state_e             state_q;
  logic [BEAT_CNT_W-1:0] beat_cnt_q;
  logic                  overrun_q;

  axi_dw_route_fifo #(
    .DATA_W (ID_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_route_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_ID_i),
    .pop_i   (last_hs),
    .data_i  (ID_i),
    .data_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_bin = head_id[ID_W-1:N_INIT_PORT];
  assign head_oh  = head_id[N_INIT_PORT-1:0];
  assign valid_id = ~fifo_empty;

  assign wready_o        = wready_i[head_bin] & valid_id;
  assign wvalid_o        = head_oh & {N_INIT_PORT{wvalid_i & valid_id}};
  assign grant_FIFO_ID_o = ~fifo_full;
  assign burst_overrun_o = overrun_q;

  assign beat_hs = wvalid_i & wready_o;
  assign last_hs = beat_hs & wlast_i;

  // Payload is broadcast unregistered to every init port; only valid is steered
  for (genvar gi = 0; gi < N_INIT_PORT; gi++) begin : g_bcast
    assign wdata_o[gi] = wdata_i;
    assign wstrb_o[gi] = wstrb_i;
    assign wlast_o[gi] = wlast_i;
    assign wuser_o[gi] = wuser_i;
  end

  // Burst FSM, beat counter and sticky overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (beat_hs && !wlast_i) state_q <= BURST;
        BURST:   if (last_hs)             state_q <= IDLE;
        default:                          state_q <= IDLE;
      endcase
      if (last_hs) begin
        beat_cnt_q <= '0;
      end else if (beat_hs) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
        if (beat_cnt_q == '1) overrun_q <= 1'b1;
      end
    end
  end

  // The head's one-hot and binary forms must name the same port
  always_ff @(posedge clk) begin
    if (!rst && valid_id) begin
      assert (head_oh == (N_INIT_PORT'(1) << head_bin));
    end
  end

endmodule

// File: tb/tb_axi_dw_distributor.sv
// Self-checking bench for axi_dw_distributor with a queue-based reference model.
module tb_axi_dw_distributor;

  logic             clk = 1'b0;
  logic             rst;
  logic [63:0]      wdata_i;
  logic [7:0]       wstrb_i;
  logic             wlast_i;
  logic [5:0]       wuser_i;
  logic             wvalid_i;
  logic             wready_o;
  logic [3:0][63:0] wdata_o;
  logic [3:0][7:0]  wstrb_o;
  logic [3:0]       wlast_o;
  logic [3:0][5:0]  wuser_o;
  logic [3:0]       wvalid_o;
  logic [3:0]       wready_i;
  logic             push_ID_i;
  logic [5:0]       ID_i;
  logic             grant_FIFO_ID_o;
  logic             burst_overrun_o;

  always #5 clk = ~clk;

  axi_dw_distributor dut (
    .clk             (clk),
    .rst             (rst),
    .wdata_i         (wdata_i),
    .wstrb_i         (wstrb_i),
    .wlast_i         (wlast_i),
    .wuser_i         (wuser_i),
    .wvalid_i        (wvalid_i),
    .wready_o        (wready_o),
    .wdata_o         (wdata_o),
    .wstrb_o         (wstrb_o),
    .wlast_o         (wlast_o),
    .wuser_o         (wuser_o),
    .wvalid_o        (wvalid_o),
    .wready_i        (wready_i),
    .push_ID_i       (push_ID_i),
    .ID_i            (ID_i),
    .grant_FIFO_ID_o (grant_FIFO_ID_o),
    .burst_overrun_o (burst_overrun_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of pending destinations, beats in current burst, sticky flag
  int mq[$];
  int beat_cnt = 0;
  bit ovf      = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model
  task automatic cycle(input bit push, input int pdst, input bit v, input bit last,
                       input logic [3:0] rdy, output bit hs);
    logic [1:0] pb;
    logic [3:0] exp_vo;
    bit         exp_ro, have, full;
    pb        = pdst[1:0];
    push_ID_i = push;
    ID_i      = {pb, 4'(4'b0001 << pb)};
    wvalid_i  = v;
    wlast_i   = last;
    wready_i  = rdy;
    wdata_i   = {$urandom, $urandom};
    wstrb_i   = 8'($urandom);
    wuser_i   = 6'($urandom);
    @(negedge clk);
    have   = (mq.size() > 0);
    exp_vo = (have && v) ? 4'(4'b0001 << mq[0]) : 4'b0000;
    exp_ro = have ? rdy[mq[0]] : 1'b0;
    chk("wvalid_o", wvalid_o, exp_vo);
    chk("wready_o", wready_o, exp_ro);
    chk("grant_FIFO_ID_o", grant_FIFO_ID_o, mq.size() < 8);
    chk("burst_overrun_o", burst_overrun_o, ovf);
    for (int p = 0; p < 4; p++)
      chk("broadcast", {wdata_o[p], wstrb_o[p], wlast_o[p], wuser_o[p]},
          {wdata_i, wstrb_i, wlast_i, wuser_i});
    hs = v && exp_ro;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      beat_cnt = 0;
      ovf      = 0;
    end else begin
      full = (mq.size() == 8);
      if (hs && last) begin
        void'(mq.pop_front());
        beat_cnt = 0;
      end else if (hs) begin
        if (beat_cnt == 255) ovf = 1;
        beat_cnt = (beat_cnt + 1) % 256;
      end
      if (push && !full) mq.push_back(pdst);
    end
    #1;
  endtask

  task automatic push_id(input int d);
    bit hs;
    cycle(1, d, 0, 0, 4'($urandom), hs);
  endtask

  // Send a whole burst to the current head; stall_pct gates head ready, rnd adds bubbles/pushes
  task automatic send_burst(input int len, input int stall_pct, input bit rnd);
    bit         hs, v, psh;
    logic [3:0] rdy;
    int         dst, guard;
    if (mq.size() == 0) push_id($urandom_range(0, 3));
    dst = mq[0];
    for (int i = 0; i < len; i++) begin
      guard = 0;
      do begin
        rdy = 4'($urandom);
        rdy[dst] = ($urandom_range(0, 99) >= stall_pct);
        v   = rnd ? ($urandom_range(0, 9) < 8) : 1'b1;
        psh = rnd && ($urandom_range(0, 3) == 0) && (mq.size() < 8);
        cycle(psh, $urandom_range(0, 3), v, i == len - 1, rdy, hs);
        guard++;
      end while (!hs && guard < 1000);
      if (!hs) chk("beat_timeout", 0, 1);
    end
    $display("[TB] burst port=%0d len=%0d queued=%0d", dst, len, mq.size());
  endtask

  initial begin
    bit hs;
    rst = 1'b1; push_ID_i = 0; ID_i = 0; wvalid_i = 0; wlast_i = 0;
    wready_i = 0; wdata_i = 0; wstrb_i = 0; wuser_i = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset_wvalid", wvalid_o, 4'b0000);
    chk("reset_wready", wready_o, 1'b0);
    chk("reset_grant", grant_FIFO_ID_o, 1'b1);
    chk("reset_overrun", burst_overrun_o, 1'b0);
    @(posedge clk); #1;

    // Single-beat burst to port 2
    push_id(2);
    cycle(0, 0, 1, 1, 4'b0100, hs);
    chk("single_hs", hs, 1'b1);
    cycle(0, 0, 1, 1, 4'b1111, hs);   // FIFO empty: no valids, no ready
    $display("[TB] single beat to port 2 done");

    // Two queued bursts: 4 beats to port 1, 2 beats to port 3
    push_id(1);
    push_id(3);
    send_burst(4, 0, 0);
    send_burst(2, 0, 0);
    chk("two_bursts_drained", mq.size(), 0);

    // Fill the FIFO, drop a 9th push, then free one slot
    for (int i = 0; i < 8; i++) push_id(i % 4);
    push_id(0);
    chk("ninth_push_dropped", mq.size(), 8);
    send_burst(1, 0, 0);
    while (mq.size() > 0) send_burst($urandom_range(1, 5), 0, 0);

    // Head stalls for 3 cycles mid-burst, then resumes
    push_id(0);
    cycle(0, 0, 1, 0, 4'b0001, hs);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 4'b1110, hs);
    cycle(0, 0, 1, 0, 4'b0001, hs);
    cycle(0, 0, 1, 1, 4'b0001, hs);
    chk("stall_burst_popped", mq.size(), 0);
    $display("[TB] stalled burst to port 0 done");

    // Randomized traffic with bubbles, stalls and overlapping pushes
    for (int i = 0; i < 25; i++) send_burst($urandom_range(1, 8), 30, 1);
    while (mq.size() > 0) send_burst($urandom_range(1, 4), 20, 0);

    // 257-beat burst triggers overrun; then reset mid-burst
    push_id(3);
    send_burst(257, 0, 0);
    chk("overrun_set", ovf, 1'b1);
    push_id(2);
    push_id(1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 4'b1111, hs);
    rst = 1'b1;
    cycle(0, 0, 1, 0, 4'b1111, hs);
    rst = 1'b0;
    cycle(0, 0, 1, 0, 4'b1111, hs);
    @(negedge clk);
    chk("post_rst_overrun", burst_overrun_o, 1'b0);
    chk("post_rst_wvalid", wvalid_o, 4'b0000);
    chk("post_rst_grant", grant_FIFO_ID_o, 1'b1);
    @(posedge clk); #1;
    send_burst(3, 10, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
